fan_duty_sched: RTL and testbench



---
 rtl/fan_pkg.sv | 39 +++
 rtl/fan_tick_gen.sv | 40 ++++
 rtl/fan_duty_sched.sv | 150 +++++++++++++++
 tb/tb_fan_duty_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// ============================================================================
//  Module      : fan_pkg
//  Description : Shared types and constants for the fan duty scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fan_pkg;

    // Width of every duty value (0..127 raw, 0..100 after conditioning)
    localparam int DUTY_W = 7;

    // Full-speed duty command
    localparam logic [DUTY_W-1:0] DUTY_MAX = 7'd100;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RAMP = 2'd2,
        HOLD = 2'd3
    } fan_state_e;

    // Clamp above DUTY_MAX and lift small non-zero requests to the running floor
    function automatic logic [DUTY_W-1:0] condition_duty(
        input logic [DUTY_W-1:0] raw,
        input logic [DUTY_W-1:0] min_duty
    );
        if (raw > DUTY_MAX)
            return DUTY_MAX;
        else if ((raw != '0) && (raw < min_duty))
            return min_duty;
        else
            return raw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fan_tick_gen.sv
// ============================================================================
//  Module      : fan_tick_gen
//  Description : Free-running prescaler producing a one-cycle ramp tick every
//                TICK_DIV clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // Wrap at TICK_DIV-1; nothing but reset restarts the count
    always_comb begin
        w_cnt_nxt = (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
    end

    // Prescaler register with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt_nxt;
    end

    assign tick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/fan_duty_sched.sv
// ============================================================================
//  Module      : fan_duty_sched
//  Description : Fan PWM duty sequencer: kick-start from stop, tick-paced
//                ramping toward the accepted target, minimum running duty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_duty_sched
    import fan_pkg::*;
#(
    parameter int TICK_DIV   = 500000,
    parameter int KICK_TICKS = 50,
    parameter int MIN_DUTY   = 20,
    parameter int STEP       = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              tgt_valid,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ready,
    output logic [DUTY_W-1:0] duty_data,
    output logic              busy,
    output logic              clamp_err
);

    localparam int                KW          = (KICK_TICKS > 1) ? $clog2(KICK_TICKS) : 1;
    localparam logic [KW-1:0]     C_KICK_LAST = KW'(KICK_TICKS - 1);
    localparam logic [DUTY_W-1:0] C_MIN       = DUTY_W'(MIN_DUTY);
    localparam logic [7:0]        C_MIN8      = 8'(MIN_DUTY);
    localparam logic [7:0]        C_STEP      = 8'(STEP);

    fan_state_e        r_state, w_state_nxt;
    logic [DUTY_W-1:0] r_duty,  w_duty_nxt;
    logic [DUTY_W-1:0] r_tgt,   w_tgt_nxt;
    logic [KW-1:0]     r_kick,  w_kick_nxt;
    logic              r_clamp, w_clamp_nxt;

    logic              w_tick;
    logic              w_accept;
    logic              w_over;
    logic [DUTY_W-1:0] w_cond;
    logic [DUTY_W-1:0] w_tgt_eff;
    logic [7:0]        w_duty8, w_tgt8, w_sum, w_ramp;
    logic [DUTY_W-1:0] w_ramp_duty;

    fan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (w_tick)
    );

    // Accept conditioning; a same-cycle accept feeds the current tick's step
    always_comb begin
        w_accept  = tgt_valid && tgt_ready;
        w_over    = (tgt_duty > DUTY_MAX);
        w_cond    = condition_duty(tgt_duty, C_MIN);
        w_tgt_eff = w_accept ? w_cond : r_tgt;
    end

    // One ramp step toward the effective target, 8-bit so +STEP cannot wrap
    always_comb begin
        w_duty8 = {1'b0, r_duty};
        w_tgt8  = {1'b0, w_tgt_eff};
        w_sum   = w_duty8 + C_STEP;
        w_ramp  = w_tgt8;
        if (w_duty8 < w_tgt8) begin
            w_ramp = (w_sum > w_tgt8) ? w_tgt8 : w_sum;
        end else if (w_duty8 > w_tgt8) begin
            w_ramp = ((w_duty8 - w_tgt8) > C_STEP) ? (w_duty8 - C_STEP) : w_tgt8;
            // Ramping to stop: drop straight to 0 once below the running floor
            if ((w_tgt8 == 8'd0) && (w_ramp < C_MIN8))
                w_ramp = 8'd0;
        end
        w_ramp_duty = w_ramp[7] ? DUTY_MAX : w_ramp[DUTY_W-1:0];
    end

    // State register and datapath flops, synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_duty  <= '0;
            r_tgt   <= '0;
            r_kick  <= '0;
            r_clamp <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_tgt   <= w_tgt_nxt;
            r_kick  <= w_kick_nxt;
            r_clamp <= w_clamp_nxt;
        end
    end

    // Next-state and next-duty decisions
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_tgt_nxt   = w_accept ? w_cond : r_tgt;
        w_kick_nxt  = r_kick;
        w_clamp_nxt = w_accept && w_over;
        case (r_state)
            IDLE: begin
                w_duty_nxt = '0;
                if (w_accept && (w_cond != '0)) begin
                    w_state_nxt = KICK;
                    w_duty_nxt  = DUTY_MAX;
                    w_kick_nxt  = '0;
                end
            end
            KICK: begin
                w_duty_nxt = DUTY_MAX;
                if (w_tick) begin
                    if (r_kick == C_KICK_LAST)
                        w_state_nxt = RAMP;
                    else
                        w_kick_nxt = r_kick + 1'b1;
                end
            end
            RAMP: begin
                if (w_tick) begin
                    w_duty_nxt = w_ramp_duty;
                    if (w_ramp_duty == w_tgt_eff)
                        w_state_nxt = (w_tgt_eff == '0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (w_accept && (w_cond != r_duty))
                    w_state_nxt = RAMP;
            end
            default: begin
                w_state_nxt = IDLE;
                w_duty_nxt  = '0;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        tgt_ready = (r_state != KICK);
        busy      = (r_state == KICK) || (r_state == RAMP);
        duty_data = r_duty;
        clamp_err = r_clamp;
    end

endmodule

`default_nettype wire

// File: tb/tb_fan_duty_sched.sv
// ============================================================================
//  Module      : tb_fan_duty_sched
//  Description : Self-checking bench for fan_duty_sched with a behavioural
//                reference model and directed plus random scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fan_duty_sched;

    localparam int TD = 4;
    localparam int KT = 3;
    localparam int MN = 20;
    localparam int ST = 5;

    localparam int MI = 0;
    localparam int MK = 1;
    localparam int MR = 2;
    localparam int MH = 3;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [6:0] tgt_duty  = 7'd0;
    logic       tgt_ready;
    logic [6:0] duty_data;
    logic       busy;
    logic       clamp_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (plain integers)
    int m_mode  = MI;
    int m_duty  = 0;
    int m_tgt   = 0;
    int m_kick  = 0;
    int m_pre   = 0;
    bit m_clamp = 1'b0;

    logic [9:0] dut_vec;
    assign dut_vec = {duty_data, tgt_ready, busy, clamp_err};

    fan_duty_sched #(
        .TICK_DIV   (TD),
        .KICK_TICKS (KT),
        .MIN_DUTY   (MN),
        .STEP       (ST)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tgt_valid (tgt_valid),
        .tgt_duty  (tgt_duty),
        .tgt_ready (tgt_ready),
        .duty_data (duty_data),
        .busy      (busy),
        .clamp_err (clamp_err)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [9:0] model_vec();
        logic [6:0] d;
        d = 7'(m_duty);
        return {d, (m_mode != MK), (m_mode == MK || m_mode == MR), m_clamp};
    endfunction

    // Advance the reference model by one clock edge
    task automatic model_update(input bit v, input int d, input bit rn);
        bit acc;
        bit tk;
        int cond;
        int nd;
        acc = v && (m_mode != MK);
        tk  = (m_pre == TD - 1);
        if (!rn) begin
            m_mode = MI; m_duty = 0; m_tgt = 0; m_kick = 0; m_pre = 0; m_clamp = 1'b0;
            return;
        end
        cond    = (d > 100) ? 100 : ((d > 0 && d < MN) ? MN : d);
        m_clamp = acc && (d > 100);
        m_pre   = (m_pre + 1) % TD;
        if (acc) m_tgt = cond;
        case (m_mode)
            MI: if (acc && cond != 0) begin
                m_mode = MK; m_duty = 100; m_kick = 0;
            end
            MK: if (tk) begin
                if (m_kick == KT - 1) m_mode = MR;
                else m_kick++;
            end
            MR: if (tk) begin
                if (m_duty < m_tgt)      nd = (m_duty + ST > m_tgt) ? m_tgt : m_duty + ST;
                else if (m_duty > m_tgt) nd = (m_duty - ST < m_tgt) ? m_tgt : m_duty - ST;
                else                     nd = m_tgt;
                if (m_tgt == 0 && nd < MN) nd = 0;
                m_duty = nd;
                if (nd == m_tgt) m_mode = (m_tgt != 0) ? MH : MI;
            end
            default: if (acc && cond != m_duty) m_mode = MR;
        endcase
    endtask

    // Drive one cycle of inputs, clock it into DUT and model, settle past the edge
    task automatic step(input bit v, input int d, input bit rn);
        sys_rst_n = rn;
        tgt_valid = v;
        tgt_duty  = d[6:0];
        @(posedge sys_clk);
        model_update(v, d, rn);
        #1;
        tgt_valid = 1'b0;
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step(1'b0, 0, 1'b0);
        step(1'b1, 60, 1'b0);
        n_checks++;
        if (dut_vec !== {7'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_state: got %b want %b", dut_vec, {7'd0, 1'b1, 1'b0, 1'b0});
        else n_pass++;
        step(1'b0, 0, 1'b1);
        n_checks++;
        if (dut_vec !== model_vec()) $display("FAIL reset_release: got %b want %b", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_kick_ramp();
        int got[$];
        int exp[$];
        int kick_obs;
        int kick_exp;
        logic [6:0] last;
        step(1'b1, 50, 1'b1);
        n_checks++;
        if ({duty_data, tgt_ready, busy} !== {7'd100, 1'b0, 1'b1})
            $display("FAIL kick_entry: got duty=%0d ready=%b busy=%b want 100/0/1", duty_data, tgt_ready, busy);
        else n_pass++;
        kick_exp = (TD - m_pre) + (KT - 1) * TD;
        kick_obs = 1;
        last = duty_data;
        for (int k = 0; k < 400; k++) begin
            step(1'b0, 0, 1'b1);
            n_checks++;
            if (dut_vec !== model_vec()) $display("FAIL kick_ramp_cycle: got %b want %b", dut_vec, model_vec());
            else n_pass++;
            if (tgt_ready === 1'b0) kick_obs++;
            if (duty_data !== last) begin got.push_back(int'(duty_data)); last = duty_data; end
            if (m_mode == MH || m_mode == MI) break;
        end
        n_checks++;
        if (kick_obs != kick_exp) $display("FAIL kick_length: got %0d cycles want %0d", kick_obs, kick_exp);
        else n_pass++;
        for (int v = 95; v >= 50; v -= ST) exp.push_back(v);
        n_checks++;
        if (got != exp) $display("FAIL ramp_down_seq: got %p want %p", got, exp);
        else n_pass++;
        n_checks++;
        if ({duty_data, busy, tgt_ready} !== {7'd50, 1'b0, 1'b1})
            $display("FAIL hold_50: got duty=%0d busy=%b ready=%b want 50/0/1", duty_data, busy, tgt_ready);
        else n_pass++;
    endtask

    task automatic test_clamp();
        step(1'b1, 120, 1'b1);
        n_checks++;
        if (clamp_err !== 1'b1) $display("FAIL clamp_pulse: got %b want 1", clamp_err);
        else n_pass++;
        step(1'b0, 0, 1'b1);
        n_checks++;
        if (clamp_err !== 1'b0) $display("FAIL clamp_one_cycle: got %b want 0", clamp_err);
        else n_pass++;
        for (int k = 0; k < 400; k++) begin
            step(1'b0, 0, 1'b1);
            n_checks++;
            if (dut_vec !== model_vec()) $display("FAIL clamp_ramp_cycle: got %b want %b", dut_vec, model_vec());
            else n_pass++;
            if (m_mode == MH) break;
        end
        n_checks++;
        if ({duty_data, busy} !== {7'd100, 1'b0}) $display("FAIL clamp_hold_100: got duty=%0d busy=%b want 100/0", duty_data, busy);
        else n_pass++;
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b1, (pass == 0) ? 50 : 7, 1'b1);
            for (int k = 0; k < 400; k++) begin
                step(1'b0, 0, 1'b1);
                n_checks++;
                if (dut_vec !== model_vec()) $display("FAIL min_ramp_cycle: got %b want %b", dut_vec, model_vec());
                else n_pass++;
                if (m_mode == MH) break;
            end
        end
        n_checks++;
        if ({duty_data, busy} !== {7'd20, 1'b0}) $display("FAIL min_duty_hold: got duty=%0d busy=%b want 20/0", duty_data, busy);
        else n_pass++;
    endtask

    task automatic test_clip_and_stop();
        int got[$];
        int exp[$];
        logic [6:0] last;
        for (int pass = 0; pass < 4; pass++) begin
            step(1'b1, (pass == 0) ? 40 : (pass == 1) ? 52 : (pass == 2) ? 50 : 0, 1'b1);
            got.delete();
            last = duty_data;
            for (int k = 0; k < 400; k++) begin
                step(1'b0, 0, 1'b1);
                n_checks++;
                if (dut_vec !== model_vec()) $display("FAIL clip_stop_cycle: got %b want %b", dut_vec, model_vec());
                else n_pass++;
                if (duty_data !== last) begin got.push_back(int'(duty_data)); last = duty_data; end
                if (m_mode == MH || m_mode == MI) break;
            end
            if (pass == 1) begin
                exp = '{45, 50, 52};
                n_checks++;
                if (got != exp) $display("FAIL clipped_up_seq: got %p want %p", got, exp);
                else n_pass++;
            end
            if (pass == 3) begin
                exp = '{45, 40, 35, 30, 25, 20, 0};
                n_checks++;
                if (got != exp) $display("FAIL stop_seq: got %p want %p", got, exp);
                else n_pass++;
            end
        end
        n_checks++;
        if ({duty_data, busy, tgt_ready} !== {7'd0, 1'b0, 1'b1})
            $display("FAIL stopped_idle: got duty=%0d busy=%b ready=%b want 0/0/1", duty_data, busy, tgt_ready);
        else n_pass++;
    endtask

    task automatic test_coincident();
        step(1'b1, 30, 1'b1);
        for (int k = 0; k < 400 && !(m_mode == MR && m_duty == 70); k++) begin
            step(1'b0, 0, 1'b1);
            n_checks++;
            if (dut_vec !== model_vec()) $display("FAIL coinc_approach: got %b want %b", dut_vec, model_vec());
            else n_pass++;
        end
        for (int k = 0; k < 2 * TD && m_pre != TD - 1; k++) begin
            step(1'b0, 0, 1'b1);
        end
        step(1'b1, 90, 1'b1);
        n_checks++;
        if (duty_data !== 7'd75) $display("FAIL coinc_step: got %0d want 75", duty_data);
        else n_pass++;
        for (int k = 0; k < 400; k++) begin
            step(1'b0, 0, 1'b1);
            n_checks++;
            if (dut_vec !== model_vec()) $display("FAIL coinc_cycle: got %b want %b", dut_vec, model_vec());
            else n_pass++;
            if (m_mode == MH) break;
        end
        n_checks++;
        if ({duty_data, busy} !== {7'd90, 1'b0}) $display("FAIL coinc_hold_90: got duty=%0d busy=%b want 90/0", duty_data, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_kick();
        int kick_obs;
        int kick_exp;
        step(1'b0, 0, 1'b0);
        step(1'b1, 30, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        n_checks++;
        if ({duty_data, tgt_ready} !== {7'd100, 1'b0}) $display("FAIL pre_reset_kick: got duty=%0d ready=%b want 100/0", duty_data, tgt_ready);
        else n_pass++;
        step(1'b0, 0, 1'b0);
        n_checks++;
        if (dut_vec !== {7'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_mid_kick: got %b want %b", dut_vec, {7'd0, 1'b1, 1'b0, 1'b0});
        else n_pass++;
        step(1'b1, 30, 1'b1);
        n_checks++;
        if ({duty_data, tgt_ready, busy} !== {7'd100, 1'b0, 1'b1})
            $display("FAIL rekick_entry: got duty=%0d ready=%b busy=%b want 100/0/1", duty_data, tgt_ready, busy);
        else n_pass++;
        kick_exp = (TD - m_pre) + (KT - 1) * TD;
        kick_obs = 1;
        for (int k = 0; k < 400; k++) begin
            step(1'b0, 0, 1'b1);
            n_checks++;
            if (dut_vec !== model_vec()) $display("FAIL rekick_cycle: got %b want %b", dut_vec, model_vec());
            else n_pass++;
            if (tgt_ready === 1'b0) kick_obs++;
            if (m_mode == MH) break;
        end
        n_checks++;
        if (kick_obs != kick_exp) $display("FAIL rekick_length: got %0d cycles want %0d", kick_obs, kick_exp);
        else n_pass++;
        n_checks++;
        if ({duty_data, busy} !== {7'd30, 1'b0}) $display("FAIL rekick_hold_30: got duty=%0d busy=%b want 30/0", duty_data, busy);
        else n_pass++;
    endtask

    task automatic test_random();
        int picks[8] = '{0, 1, 19, 20, 21, 100, 101, 127};
        int d;
        bit v;
        bit rn;
        for (int k = 0; k < 3000; k++) begin
            v  = ($urandom_range(0, 5) == 0);
            d  = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 7)] : int'($urandom_range(0, 127));
            rn = ($urandom_range(0, 399) != 0);
            step(v, d, rn);
            n_checks++;
            if (dut_vec !== model_vec()) $display("FAIL random_cycle %0d: got %b want %b", k, dut_vec, model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_kick_ramp();
        test_clamp();
        test_clip_and_stop();
        test_coincident();
        test_reset_mid_kick();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
